// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state type and the rotating-priority pick helper
// for the 4-requester round-robin arbiter.
//   NUM_REQ     number of requesters
//   ID_W        width of a binary requester index
//   arb_state_t IDLE (no owner) / GRANT (one owner holds the resource)
//   pick_rr     first set request bit searching ptr, ptr+1, .. (mod NUM_REQ)
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Walks the offsets from the far end back to 0 so the smallest offset from
  // ptr (the highest priority) is the last assignment and therefore wins.
  // Returns ptr when nothing is requested; callers only use it when req != 0.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    win = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/gnt_encoder_4x2.sv
// gnt_encoder_4x2: combinational one-hot to binary encoder for the next grant.
//   onehot  in   NUM_REQ  one-hot (or all-zero) grant vector
//   id      out  ID_W     binary index of the set bit (0 when all-zero)
//   valid   out  1        high iff any bit of onehot is set
module gnt_encoder_4x2
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Mask of the requester positions whose index has bit b set.
  function automatic logic [NUM_REQ-1:0] idx_mask(input int b);
    logic [NUM_REQ-1:0] m;
    for (int i = 0; i < NUM_REQ; i++) begin
      m[i] = ((i >> b) & 1) != 0;
    end
    return m;
  endfunction

  // With a one-hot input each id bit is just the OR of the positions that
  // carry that bit in their index.
  genvar gi;
  generate
    for (gi = 0; gi < ID_W; gi++) begin : g_id
      assign id[gi] = |(onehot & idx_mask(gi));
    end
  endgenerate

  assign valid = |onehot;

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-requester round-robin arbiter with a per-owner hold limit.
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   req        in   4  request per agent, held for the whole transaction
//   gnt        out  4  registered one-hot grant (zero when idle)
//   gnt_id     out  2  binary index of gnt (zero when idle)
//   gnt_valid  out  1  high iff gnt != 0
// Parameter MAX_HOLD: max consecutive grant cycles for one owner while others
// wait; 0 means the owner may hold indefinitely.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};

  arb_state_t         state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
  logic               gnt_valid_reg, gnt_valid_next;

  logic               owner_req;
  logic               others_req;
  logic               limit_hit;
  logic               take;
  logic [ID_W-1:0]    winner;

  assign owner_req  = |(req & gnt_reg);
  assign others_req = |(req & ~gnt_reg);
  assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT);

  // While granted, ptr already sits one past the owner, so searching the raw
  // req vector from ptr puts a still-requesting owner last: on preemption the
  // pick always lands on another agent without masking the owner out.
  assign winner = pick_rr(req, ptr_reg);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    take          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
        end
      end
      GRANT: begin
        if (owner_req) begin
          if (!limit_hit) begin
            // Saturating count keeps the unlimited case from wrapping.
            if (hold_cnt_reg != HOLD_SAT) begin
              hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
          end else if (others_req) begin
            take = 1'b1;
          end
        end else if (others_req) begin
          take = 1'b1;
        end else begin
          state_next    = IDLE;
          gnt_next      = '0;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        hold_cnt_next = '0;
      end
    endcase

    if (take) begin
      state_next    = GRANT;
      gnt_next      = NUM_REQ'(1) << winner;
      hold_cnt_next = HOLD_W'(1);
      ptr_next      = winner + ID_W'(1);
    end
  end

  // Encode the next grant so id and valid are registered alongside gnt and
  // never lag it by a cycle.
  gnt_encoder_4x2 u_enc (
    .onehot (gnt_next),
    .id     (gnt_id_next),
    .valid  (gnt_valid_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_id_reg    <= '0;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      gnt_reg       <= gnt_next;
      gnt_id_reg    <= gnt_id_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4 (MAX_HOLD = 2): directed scenarios followed by
// random requests, all checked against a behavioural owner/ptr/hold model.
module tb_rr_arbiter_4;

  localparam int MAXH      = 2;
  localparam int WAIT_MAX  = 3 * MAXH + 3;
  localparam int N_RANDOM  = 10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the resource (-1 = nobody), how long it has
  // held it, and which agent currently has top priority.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_take(input logic [3:0] r);
    int w;
    w       = pick(r, m_ptr);
    m_owner = w;
    m_held  = 1;
    m_ptr   = (w + 1) % 4;
  endtask

  // One clock edge of the arbitration rules, applied to the sampled req.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    if (m_owner < 0) begin
      if (r != 4'b0000) model_take(r);
    end else begin
      others = r & ~(4'b0001 << m_owner);
      if (r[m_owner]) begin
        if (MAXH == 0 || m_held < MAXH) begin
          if (MAXH != 0) m_held++;
        end else if (others != 4'b0000) begin
          model_take(r);
        end
      end else if (others != 4'b0000) begin
        model_take(r);
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_gnt;
    int         enc;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check_eq({tag, "_gnt"},   gnt,       exp_gnt);
    check_eq({tag, "_id"},    gnt_id,    (m_owner < 0) ? 0 : m_owner);
    check_eq({tag, "_valid"}, gnt_valid, (m_owner < 0) ? 0 : 1);
    // Structural invariants on the observed grant itself.
    enc = 0;
    for (int i = 0; i < 4; i++) if (gnt[i]) enc = i;
    check_eq({tag, "_onehot0"}, ($countones(gnt) <= 1) ? 1 : 0, 1);
    check_eq({tag, "_enc"},     gnt_id,    enc);
    check_eq({tag, "_orv"},     gnt_valid, (gnt != 4'b0000) ? 1 : 0);
  endtask

  // Called at a falling edge: drive req, let one rising edge pass, check.
  task automatic cycle(input logic [3:0] r, input string tag, input bit verbose);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_outputs(tag);
    if (verbose)
      $display("%s req=%b gnt=%b id=%0d valid=%0b", tag, r, gnt, gnt_id, gnt_valid);
  endtask

  // Async reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, "_gnt"},   gnt,       0);
    check_eq({tag, "_id"},    gnt_id,    0);
    check_eq({tag, "_valid"}, gnt_valid, 0);
    $display("%s async reset gnt=%b id=%0d valid=%0b", tag, gnt, gnt_id, gnt_valid);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [3:0] t2_seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001};

  int  r_dur  [4];
  int  r_got  [4];
  int  r_wait [4];
  logic [3:0] r_req;
  int  last_owner;

  initial begin
    // Test 1: reset held with all requests active, then a single request.
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs("t1_rst");
    $display("t1 in reset req=%b gnt=%b id=%0d valid=%0b", req, gnt, gnt_id, gnt_valid);
    rst = 1'b0;
    cycle(4'b0001, "t1", 1'b1);
    check_eq("t1_gnt_const", gnt, 4'b0001);

    // Test 2: constant full request rotates every MAX_HOLD cycles.
    @(negedge clk);
    pulse_reset("t2");
    for (int i = 0; i < 9; i++) begin
      cycle(4'b1111, "t2", 1'b1);
      check_eq("t2_seq", gnt, t2_seq[i]);
    end

    // Test 3: lone requester keeps its grant past the hold limit.
    pulse_reset("t3");
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0100, "t3", 1'b1);
      check_eq("t3_gnt_const", gnt, 4'b0100);
    end

    // Test 4: owner drops while another waits; handover with no idle cycle.
    pulse_reset("t4");
    cycle(4'b0001, "t4", 1'b1);
    cycle(4'b0101, "t4", 1'b1);
    check_eq("t4_valid_hold", gnt_valid, 1);
    cycle(4'b0100, "t4", 1'b1);
    check_eq("t4_handover", gnt, 4'b0100);
    check_eq("t4_valid_hold", gnt_valid, 1);

    // Test 5: async reset mid-grant, then ptr must be back at 0.
    pulse_reset("t5");
    cycle(4'b1000, "t5", 1'b1);
    check_eq("t5_gnt3", gnt, 4'b1000);
    pulse_reset("t5_mid");
    cycle(4'b1001, "t5", 1'b1);
    check_eq("t5_ptr0", gnt, 4'b0001);

    // Test 6: random traffic. Each agent raises req, keeps it until it has
    // been granted for a random number of cycles, then drops it.
    pulse_reset("t6");
    r_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      r_dur[i] = 0; r_got[i] = 0; r_wait[i] = 0;
    end
    last_owner = -1;
    for (int c = 0; c < N_RANDOM; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!r_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            r_req[i]  = 1'b1;
            r_dur[i]  = $urandom_range(1, 4);
            r_got[i]  = 0;
            r_wait[i] = 0;
          end
        end else if (r_got[i] >= r_dur[i]) begin
          r_req[i] = 1'b0;
        end
      end
      cycle(r_req, "t6", 1'b0);
      if (m_owner != last_owner && m_owner >= 0)
        $display("t6 cycle %0d grant to agent %0d req=%b", c, m_owner, r_req);
      last_owner = m_owner;
      for (int i = 0; i < 4; i++) begin
        if (r_req[i]) begin
          if (m_owner == i) begin
            r_got[i]++;
            r_wait[i] = 0;
          end else begin
            r_wait[i]++;
            check_eq("t6_wait_bound", (r_wait[i] > WAIT_MAX) ? 1 : 0, 0);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
